// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
// Shared Gray-code helpers for the Gray counter, the Gray-to-binary converter
// and their benches.
//
// Contents:
//   GRAY_W_DEFAULT : default code width (4)
//   GRAY_FN_W      : working width of the helper functions (32)
//   bin2gray()     : binary -> Gray
//   gray2bin()     : Gray -> binary
//
// The helpers are width-agnostic. Zero-extend a narrower operand to
// GRAY_FN_W bits, then keep the low bits of the result. Zero upper bits map
// to zero upper bits in both directions, so the low WIDTH bits of the result
// are exactly the WIDTH-bit conversion.
// ---------------------------------------------------------------------------
package gray_pkg;

   localparam int GRAY_W_DEFAULT = 4;
   localparam int GRAY_FN_W      = 32;

   function automatic logic [GRAY_FN_W-1:0] bin2gray(input logic [GRAY_FN_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   // This is a prefix XOR taken from the MSB downward.
   function automatic logic [GRAY_FN_W-1:0] gray2bin(input logic [GRAY_FN_W-1:0] gv);
      logic [GRAY_FN_W-1:0] b;
      b[GRAY_FN_W-1] = gv[GRAY_FN_W-1];
      for (int i = GRAY_FN_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ gv[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_code_counter_bin_to_gray.sv
// ---------------------------------------------------------------------------
// bin_to_gray
// Purely combinational binary-to-Gray mapper. It sits in front of the Gray
// output register of gray_code_counter.
//
// Parameters:
//   WIDTH  : code width in bits (>= 2)
// Ports:
//   bin_i  : in  [WIDTH-1:0] binary value
//   gray_o : out [WIDTH-1:0] Gray-coded value
// ---------------------------------------------------------------------------
module bin_to_gray
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_W_DEFAULT
) (
   input  logic [WIDTH-1:0] bin_i,
   output logic [WIDTH-1:0] gray_o
);

   assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_code_counter.sv
// ---------------------------------------------------------------------------
// gray_code_counter
// Up/down counter. The count is held in binary and presented as a registered
// Gray code, so g changes by exactly one bit per count step. That makes g
// safe to synchronise into another clock domain.
//
// Parameters:
//   WIDTH    : counter/code width in bits (>= 2)
// Ports:
//   clk      : in  rising-edge clock
//   rst_n    : in  asynchronous active-low reset
//   en       : in  count enable
//   up_dn    : in  1 = increment, 0 = decrement
//   load     : in  synchronous load strobe (highest priority)
//   load_bin : in  [WIDTH-1:0] binary load value
//   g        : out [WIDTH-1:0] registered Gray count
//   g_vld    : out pulses for one cycle whenever g took a new value
//   tc       : out terminal-count pulse, asserted in the cycle the count wrapped
//   err      : out sticky Gray-violation flag
//
// Build option:
//   GRAY_CODE_COUNTER_CHECK_EN : when defined, an inline checker sets err if
//   a count step changed g by anything other than exactly one bit. When
//   undefined, err is tied to 0.
// ---------------------------------------------------------------------------
module gray_code_counter
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   output logic [WIDTH-1:0] g,
   output logic             g_vld,
   output logic             tc,
   output logic             err
);

   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] g_q, g_d;
   logic             tc_q, tc_d;
   logic             vld_q, vld_d;

   // One extra bit catches the carry on increment and the borrow on decrement.
   // That bit feeds tc only; the count itself wraps modulo 2^WIDTH.
   logic [WIDTH:0]   inc_w, dec_w;

   assign inc_w = {1'b0, bin_q} + {{WIDTH{1'b0}}, 1'b1};
   assign dec_w = {1'b0, bin_q} - {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      bin_d = bin_q;
      tc_d  = 1'b0;
      vld_d = 1'b0;
      if (load) begin
         bin_d = load_bin;
         vld_d = 1'b1;
      end else if (en) begin
         vld_d = 1'b1;
         if (up_dn) begin
            bin_d = inc_w[WIDTH-1:0];
            tc_d  = inc_w[WIDTH];
         end else begin
            bin_d = dec_w[WIDTH-1:0];
            tc_d  = dec_w[WIDTH];
         end
      end
   end

   // Encode the next binary value, not the current one, so g is a plain
   // register with no decode logic between it and the output pin.
   bin_to_gray #(
      .WIDTH (WIDTH)
   ) u_bin_to_gray (
      .bin_i  (bin_d),
      .gray_o (g_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q <= '0;
         g_q   <= '0;
         tc_q  <= 1'b0;
         vld_q <= 1'b0;
      end else begin
         bin_q <= bin_d;
         g_q   <= g_d;
         tc_q  <= tc_d;
         vld_q <= vld_d;
      end
   end

   assign g     = g_q;
   assign tc    = tc_q;
   assign g_vld = vld_q;

`ifdef GRAY_CODE_COUNTER_CHECK_EN
   // step_q is set when the last update of g_q was a count step.
   // A load may jump by any number of bits, so it is not checked.
   logic [WIDTH-1:0] g_prev_q;
   logic             step_q;
   logic             err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_prev_q <= '0;
         step_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         g_prev_q <= g_q;
         step_q   <= en & ~load;
         if (step_q && ($countones(g_q ^ g_prev_q) != 1)) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_code_counter.sv
// ---------------------------------------------------------------------------
// tb_gray_code_counter
// Directed bench for gray_code_counter (WIDTH = 4), followed by a
// model-checked random run.
// ---------------------------------------------------------------------------
module tb_gray_code_counter;
   import gray_pkg::*;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         en;
   logic         up_dn;
   logic         load;
   logic [W-1:0] load_bin;
   logic [W-1:0] g;
   logic         g_vld;
   logic         tc;
   logic         err;

   int n_checks;
   int n_errors;

   gray_code_counter #(
      .WIDTH (W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up_dn    (up_dn),
      .load     (load),
      .load_bin (load_bin),
      .g        (g),
      .g_vld    (g_vld),
      .tc       (tc),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one clock edge. Return on the falling edge, so outputs are
   // sampled away from the active edge and inputs can be driven then.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_g",   32'(g),     32'h0);
      check("rst_tc",  32'(tc),    32'h0);
      check("rst_vld", 32'(g_vld), 32'h0);
      check("rst_err", 32'(err),   32'h0);
      tick();
      rst_n = 1'b1;
   endtask

   logic [W-1:0] up_seq [16];
   logic [W-1:0] mb, nb, lb;
   logic         etc, ev, ld, e, u;

   initial begin
      n_checks = 0;
      n_errors = 0;
      up_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
      rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_bin = '0;
      @(negedge clk);
      do_reset();

      // Idle after reset: nothing moves.
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle_g",   32'(g),     32'h0);
         check("idle_tc",  32'(tc),    32'h0);
         check("idle_vld", 32'(g_vld), 32'h0);
      end

      // Full count-up cycle; tc appears only on the wrap back to 0000.
      en = 1'b1; up_dn = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         check("up_g",   32'(g),     32'(up_seq[i]));
         check("up_tc",  32'(tc),    (i == 15) ? 32'h1 : 32'h0);
         check("up_vld", 32'(g_vld), 32'h1);
      end

      // Hold: g keeps its value and g_vld drops.
      en = 1'b0;
      tick();
      check("hold_g",   32'(g),     32'h0);
      check("hold_vld", 32'(g_vld), 32'h0);

      // Decrement from reset wraps to binary 15 (Gray 1000) and pulses tc.
      do_reset();
      en = 1'b1; up_dn = 1'b0;
      tick();
      check("dn_g",   32'(g),     32'h8);
      check("dn_tc",  32'(tc),    32'h1);
      check("dn_vld", 32'(g_vld), 32'h1);

      // Load overrides en/up_dn: binary 10 gives Gray 1111.
      load = 1'b1; load_bin = 4'd10; up_dn = 1'b1;
      tick();
      check("ld_g",   32'(g),     32'hF);
      check("ld_tc",  32'(tc),    32'h0);
      check("ld_vld", 32'(g_vld), 32'h1);
      load = 1'b0;
      tick();
      check("ld_up_g", 32'(g), 32'hE);   // binary 11
      // Loading the value already held still pulses g_vld.
      load = 1'b1; load_bin = 4'd11; en = 1'b0;
      tick();
      check("ldsame_g",   32'(g),     32'hE);
      check("ldsame_vld", 32'(g_vld), 32'h1);
      load = 1'b0;

      // Turn around mid-count: 11 -> 12 -> 11.
      en = 1'b1; up_dn = 1'b1;
      tick();
      check("turn_up_g", 32'(g), 32'hA);   // binary 12
      up_dn = 1'b0;
      tick();
      check("turn_dn_g", 32'(g), 32'hE);   // binary 11
      check("turn_tc",   32'(tc), 32'h0);

      // Asynchronous reset between edges while g = 0110 (binary 4).
      do_reset();
      en = 1'b1; up_dn = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("pre_arst_g", 32'(g), 32'h6);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_g",   32'(g),     32'h0);
      check("arst_tc",  32'(tc),    32'h0);
      check("arst_vld", 32'(g_vld), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_arst_g", 32'(g), 32'h1);   // counting restarts from 0

      // Random traffic against a reference model.
      en = 1'b0; up_dn = 1'b1; load = 1'b0;
      do_reset();
      mb = '0;
      for (int i = 0; i < 1000; i++) begin
         ld = ($urandom_range(0, 9) == 0);
         e  = 1'($urandom_range(0, 1));
         u  = 1'($urandom_range(0, 1));
         lb = 4'($urandom_range(0, 15));
         nb = mb; etc = 1'b0; ev = 1'b0;
         if (ld) begin
            nb = lb; ev = 1'b1;
         end else if (e) begin
            ev = 1'b1;
            if (u) begin
               etc = (mb == 4'hF); nb = mb + 4'd1;
            end else begin
               etc = (mb == 4'h0); nb = mb - 4'd1;
            end
         end
         load = ld; en = e; up_dn = u; load_bin = lb;
         tick();
         check("rnd_bin", gray2bin(32'(g)), 32'(nb));
         check("rnd_tc",  32'(tc),    32'(etc));
         check("rnd_vld", 32'(g_vld), 32'(ev));
         check("rnd_err", 32'(err),   32'h0);
         mb = nb;
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
